// File: rtl/wb_bram_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The master modport drives the request side; the slave modport returns data, ack and err.
interface wb_bram_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_bram_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of one block-RAM slave port.
// Define WB_ARB_TIMEOUT_EN to build the stalled-ack watchdog that returns err after TIMEOUT cycles.
module wb_bram_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_bram_arbiter_if.slave   m0,
    wb_bram_arbiter_if.slave   m1,
    wb_bram_arbiter_if.master  s
);

    typedef enum logic [1:0] {IDLE, G0, G1} grant_t;

    grant_t grant, grant_nxt;
    logic   last, last_nxt;
    logic   timeout_hit;
    logic   unused_ok;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       stalled;

    assign stalled = ~s.ack & (((grant == G0) & m0.stb) | ((grant == G1) & m1.stb));
    assign timeout_hit = stalled & (tmo_cnt == 8'(TIMEOUT - 1));

    // Counts consecutive stalled strobe cycles within one tenure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (!stalled || grant_nxt != grant) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign unused_ok = s.err;
`else
    assign timeout_hit = 1'b0;
    assign unused_ok   = s.err | (TIMEOUT == 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant <= IDLE;
            last  <= 1'b1;
        end else begin
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Releasing master becomes 'last' so a waiting peer always wins the next arbitration.
    always_comb begin
        grant_nxt = grant;
        last_nxt  = last;
        case (grant)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    grant_nxt = last ? G0 : G1;
                end else if (m0.cyc) begin
                    grant_nxt = G0;
                end else if (m1.cyc) begin
                    grant_nxt = G1;
                end
            end
            G0: begin
                if (timeout_hit) begin
                    last_nxt  = 1'b0;
                    grant_nxt = IDLE;
                end else if (!m0.cyc) begin
                    last_nxt  = 1'b0;
                    grant_nxt = m1.cyc ? G1 : IDLE;
                end
            end
            G1: begin
                if (timeout_hit) begin
                    last_nxt  = 1'b1;
                    grant_nxt = IDLE;
                end else if (!m1.cyc) begin
                    last_nxt  = 1'b1;
                    grant_nxt = m0.cyc ? G0 : IDLE;
                end
            end
            default: grant_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        case (grant)
            G0: begin
                s.cyc   = m0.cyc & ~timeout_hit;
                s.stb   = m0.stb & ~timeout_hit;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
                s.sel   = m0.sel;
            end
            G1: begin
                s.cyc   = m1.cyc & ~timeout_hit;
                s.stb   = m1.stb & ~timeout_hit;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
                s.sel   = m1.sel;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0.dat_r = rst_i ? '0 : s.dat_r;
    assign m1.dat_r = rst_i ? '0 : s.dat_r;
    assign m0.ack   = s.ack & (grant == G0);
    assign m1.ack   = s.ack & (grant == G1);
    assign m0.err   = timeout_hit & (grant == G0);
    assign m1.err   = timeout_hit & (grant == G1);

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed self-checking bench for wb_bram_arbiter with a small byte-lane RAM slave model.
// Stall behaviour is checked against whichever WB_ARB_TIMEOUT_EN build is compiled.
module tb_wb_bram_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    wb_bram_arbiter_if m0_bus ();
    wb_bram_arbiter_if m1_bus ();
    wb_bram_arbiter_if s_bus ();

    wb_bram_arbiter #(.TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    always #5 clk_i = ~clk_i;

    // Slave side: either a toggling-ack RAM model or directly driven ack/data.
    logic        auto_slave = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_dat = '0;
    logic        mdl_ack;
    logic [31:0] mdl_dat;
    logic [31:0] mem [16];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdl_ack <= 1'b0;
            mdl_dat <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            mdl_ack <= s_bus.cyc & s_bus.stb & ~mdl_ack;
            mdl_dat <= mem[s_bus.adr[5:2]];
            if (s_bus.cyc && s_bus.stb && s_bus.we && !mdl_ack) begin
                for (int b = 0; b < 4; b++)
                    if (s_bus.sel[b]) mem[s_bus.adr[5:2]][8*b +: 8] <= s_bus.dat_w[8*b +: 8];
            end
        end
    end

    assign s_bus.ack   = auto_slave ? mdl_ack : man_ack;
    assign s_bus.dat_r = auto_slave ? mdl_dat : man_dat;
    assign s_bus.err   = 1'b0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        logic [31:0] exp_adr;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        man_dat = 32'h1234_5678;
        tick(); tick();
        checkOutput("rst_s_cyc", s_bus.cyc, 0);
        checkOutput("rst_m0_ack", m0_bus.ack, 0);
        checkOutput("rst_m0_err", m0_bus.err, 0);
        checkOutput("rst_m0_dat", m0_bus.dat_r, 0);
        rst_i = 1'b0;
        man_dat = 32'h0;

        // Single master read.
        tick();
        applyStimulus(0, 1, 1, 0, 32'h10, 32'h0, 4'hF);
        checkOutput("lat_s_stb_t", s_bus.stb, 0);
        tick();
        checkOutput("single_s_stb", s_bus.stb, 1);
        checkOutput("single_s_adr", s_bus.adr, 32'h10);
        man_ack = 1'b1; man_dat = 32'hCAFE_0001; #1;
        checkOutput("single_m0_ack", m0_bus.ack, 1);
        checkOutput("single_m0_dat", m0_bus.dat_r, 32'hCAFE_0001);
        checkOutput("single_m1_ack", m1_bus.ack, 0);
        man_ack = 1'b0; #1;
        checkOutput("single_m0_ack_lo", m0_bus.ack, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("single_idle", s_bus.cyc, 0);

        // Simultaneous requests after reset: master 0 first, then zero-bubble handover.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        applyStimulus(0, 1, 1, 0, 32'h100, 32'h0, 4'hF);
        applyStimulus(1, 1, 1, 0, 32'h200, 32'h0, 4'hF);
        tick();
        checkOutput("tie_g0_adr", s_bus.adr, 32'h100);
        tick();
        checkOutput("tie_g0_hold", s_bus.adr, 32'h100);
        applyStimulus(0, 0, 0, 0, 32'h100, 32'h0, 4'hF);
        checkOutput("tie_g0_release_cyc", s_bus.cyc, 0);
        tick();
        checkOutput("handover_g1_cyc", s_bus.cyc, 1);
        checkOutput("handover_g1_adr", s_bus.adr, 32'h200);

        // Fairness: both request continuously, each releases after a few cycles.
        applyStimulus(0, 1, 1, 0, 32'h100, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            exp_adr = (k % 2 == 0) ? 32'h200 : 32'h100;
            for (int c = 0; c < 3; c++) begin
                checkOutput("fair_hold", s_bus.adr, exp_adr);
                tick();
            end
            if (k % 2 == 0) applyStimulus(1, 0, 0, 0, 32'h200, 32'h0, 4'hF);
            else            applyStimulus(0, 0, 0, 0, 32'h100, 32'h0, 4'hF);
            tick();
            checkOutput("fair_switch", s_bus.adr, (k % 2 == 0) ? 32'h100 : 32'h200);
            if (k % 2 == 0) applyStimulus(1, 1, 1, 0, 32'h200, 32'h0, 4'hF);
            else            applyStimulus(0, 1, 1, 0, 32'h100, 32'h0, 4'hF);
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("fair_idle", s_bus.cyc, 0);

        // Write forwarding and byte-lane read-back through master 1.
        auto_slave = 1'b1;
        applyStimulus(1, 1, 1, 1, 32'h8, 32'hDEAD_BEEF, 4'b0101);
        tick();
        checkOutput("wr_s_dat", s_bus.dat_w, 32'hDEAD_BEEF);
        checkOutput("wr_s_sel", s_bus.sel, 4'b0101);
        checkOutput("wr_s_we", s_bus.we, 1);
        tick();
        checkOutput("wr_m1_ack", m1_bus.ack, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        applyStimulus(1, 1, 1, 0, 32'h8, 32'h0, 4'hF);
        tick();
        checkOutput("rd_m1_ack_wait", m1_bus.ack, 0);
        tick();
        checkOutput("rd_m1_ack", m1_bus.ack, 1);
        checkOutput("rd_m1_dat", m1_bus.dat_r, 32'h00AD_00EF);
        checkOutput("rd_m0_ack", m0_bus.ack, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        auto_slave = 1'b0;

        // Asynchronous reset in the middle of a granted cycle.
        applyStimulus(0, 1, 1, 0, 32'h40, 32'h0, 4'hF);
        tick();
        man_ack = 1'b1; #1;
        checkOutput("arst_pre_ack", m0_bus.ack, 1);
        checkOutput("arst_pre_cyc", s_bus.cyc, 1);
        #2;
        rst_i = 1'b1; #1;
        checkOutput("arst_s_cyc", s_bus.cyc, 0);
        checkOutput("arst_m0_ack", m0_bus.ack, 0);
        man_ack = 1'b0;
        tick();
        rst_i = 1'b0; #1;
        checkOutput("arst_release_idle", s_bus.cyc, 0);
        applyStimulus(1, 1, 1, 0, 32'h80, 32'h0, 4'hF);
        tick();
        checkOutput("stall_g0_adr", s_bus.adr, 32'h40);

`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            checkOutput("tmo_err_early", m0_bus.err, 0);
            tick();
        end
        checkOutput("tmo_err_pulse", m0_bus.err, 1);
        checkOutput("tmo_s_cyc_forced", s_bus.cyc, 0);
        checkOutput("tmo_m1_err", m1_bus.err, 0);
        tick();
        checkOutput("tmo_idle", s_bus.cyc, 0);
        checkOutput("tmo_err_cleared", m0_bus.err, 0);
        tick();
        checkOutput("tmo_m1_granted", s_bus.adr, 32'h80);
`else
        for (int c = 0; c < 20; c++) begin
            checkOutput("stall_hold_cyc", s_bus.cyc, 1);
            checkOutput("stall_no_err", m0_bus.err, 0);
            tick();
        end
        checkOutput("stall_still_g0", s_bus.adr, 32'h40);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("stall_m1_granted", s_bus.adr, 32'h80);
`endif
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("end_idle", s_bus.cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
